// File: rtl/scoreboard_dispatcher.sv
// Command dispatcher: looks each command up in an external scoreboard, allocates the
// lowest free processor on a miss, and hands the command to that processor.
module scoreboard_dispatcher #(
  parameter int PROC_COUNT = 4,
  parameter int CMD_W      = 8,
  parameter int TIMEOUT    = 32,
  localparam int PID_W     = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cmd_valid,
  input  logic [CMD_W-1:0]      i_cmd_id,
  output logic                  o_cmd_ready,
  input  logic                  i_flush_req,
  output logic                  o_sb_read,
  output logic                  o_sb_write,
  output logic                  o_sb_flush,
  output logic [CMD_W-1:0]      o_sb_cmd_id,
  output logic [PID_W-1:0]      o_sb_proc_id,
  input  logic                  i_sb_ack,
  input  logic                  i_sb_exists,
  input  logic [PID_W-1:0]      i_sb_id,
  output logic                  o_disp_valid,
  output logic [CMD_W-1:0]      o_disp_cmd_id,
  output logic [PID_W-1:0]      o_disp_proc_id,
  input  logic                  i_disp_ready,
  input  logic [PROC_COUNT-1:0] i_proc_done,
  output logic [PROC_COUNT-1:0] o_busy_map,
  output logic                  o_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WAIT_RD, ALLOC, WRITE, WAIT_WR, DISPATCH, FLUSH, WAIT_FL
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CMD_W-1:0]      r_cmdId;
  logic [PID_W-1:0]      r_proc;
  logic [PROC_COUNT-1:0] r_busy;
  logic                  r_err;
  logic [CNT_W-1:0]      r_waitCnt;

  logic                  w_accept;
  logic                  w_inWait;
  logic                  w_timeout;
  logic                  w_flushClr;
  logic                  w_anyFree;
  logic [PID_W-1:0]      w_freeIdx;
  logic [PROC_COUNT-1:0] w_setMask;

  assign w_accept   = (r_state == IDLE) && !i_flush_req && i_cmd_valid;
  assign w_inWait   = (r_state == WAIT_RD) || (r_state == WAIT_WR) || (r_state == WAIT_FL);
  assign w_timeout  = w_inWait && !i_sb_ack && (r_waitCnt == CNT_W'(TIMEOUT - 1));
  assign w_flushClr = (r_state == WAIT_FL) && i_sb_ack;

  // Descending scan so the lowest-index free processor is the one that sticks.
  always_comb begin
    w_anyFree = 1'b0;
    w_freeIdx = '0;
    for (int k = PROC_COUNT - 1; k >= 0; k--) begin
      if (!r_busy[k]) begin
        w_anyFree = 1'b1;
        w_freeIdx = PID_W'(k);
      end
    end
  end

  always_comb begin
    w_setMask = '0;
    if (r_state == WRITE) w_setMask[r_proc] = 1'b1;
  end

  always_comb begin
    w_nextState  = r_state;
    o_cmd_ready  = 1'b0;
    o_sb_read    = 1'b0;
    o_sb_write   = 1'b0;
    o_sb_flush   = 1'b0;
    o_disp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = i_rstn && !i_flush_req;
        if (i_flush_req)      w_nextState = FLUSH;
        else if (i_cmd_valid) w_nextState = LOOKUP;
      end
      LOOKUP: begin
        o_sb_read   = 1'b1;
        w_nextState = WAIT_RD;
      end
      WAIT_RD: begin
        if (i_sb_ack)       w_nextState = i_sb_exists ? DISPATCH : ALLOC;
        else if (w_timeout) w_nextState = IDLE;
      end
      ALLOC: begin
        if (w_anyFree) w_nextState = WRITE;
      end
      WRITE: begin
        o_sb_write  = 1'b1;
        w_nextState = WAIT_WR;
      end
      WAIT_WR: begin
        if (i_sb_ack)       w_nextState = DISPATCH;
        else if (w_timeout) w_nextState = IDLE;
      end
      DISPATCH: begin
        o_disp_valid = 1'b1;
        if (i_disp_ready) w_nextState = IDLE;
      end
      FLUSH: begin
        o_sb_flush  = 1'b1;
        w_nextState = WAIT_FL;
      end
      WAIT_FL: begin
        if (i_sb_ack || w_timeout) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A processor freed in the same cycle it is being allocated stays busy.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= IDLE;
      r_cmdId   <= '0;
      r_proc    <= '0;
      r_busy    <= '0;
      r_err     <= 1'b0;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= w_flushClr ? '0 : ((r_busy & ~i_proc_done) | w_setMask);
      if (w_accept) r_cmdId <= i_cmd_id;
      if ((r_state == WAIT_RD) && i_sb_ack && i_sb_exists) r_proc <= i_sb_id;
      else if ((r_state == ALLOC) && w_anyFree)           r_proc <= w_freeIdx;
      if (w_flushClr)     r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      if (r_state != w_nextState) r_waitCnt <= '0;
      else if (w_inWait)          r_waitCnt <= r_waitCnt + CNT_W'(1);
    end
  end

  assign o_sb_cmd_id    = r_cmdId;
  assign o_sb_proc_id   = r_proc;
  assign o_disp_cmd_id  = r_cmdId;
  assign o_disp_proc_id = r_proc;
  assign o_busy_map     = r_busy;
  assign o_err          = r_err;

endmodule

// File: tb/tb_scoreboard_dispatcher.sv
// Directed bench for scoreboard_dispatcher with a transaction-level model checked
// every cycle on the falling clock edge.
module tb_scoreboard_dispatcher;

  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmdValid, flushReq, sbAck, sbExists, dispReady;
  logic [7:0] cmdId;
  logic [1:0] sbId;
  logic [3:0] procDone;

  logic       cmdReady, sbRead, sbWrite, sbFlush, dispValid, err;
  logic [7:0] sbCmdId, dispCmdId;
  logic [1:0] sbProcId, dispProcId;
  logic [3:0] busyMap;

  int checks = 0;
  int failures = 0;

  scoreboard_dispatcher #(.PROC_COUNT(4), .CMD_W(8), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cmd_valid(cmdValid), .i_cmd_id(cmdId), .o_cmd_ready(cmdReady),
    .i_flush_req(flushReq),
    .o_sb_read(sbRead), .o_sb_write(sbWrite), .o_sb_flush(sbFlush),
    .o_sb_cmd_id(sbCmdId), .o_sb_proc_id(sbProcId),
    .i_sb_ack(sbAck), .i_sb_exists(sbExists), .i_sb_id(sbId),
    .o_disp_valid(dispValid), .o_disp_cmd_id(dispCmdId), .o_disp_proc_id(dispProcId),
    .i_disp_ready(dispReady), .i_proc_done(procDone),
    .o_busy_map(busyMap), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, then returns just after the edge with quiet defaults.
  task automatic applyStimulus(input logic v, input logic [7:0] id, input logic fl,
                               input logic ack, input logic ex, input logic [1:0] sid,
                               input logic [3:0] done, input logic rdy);
    cmdValid = v; cmdId = id; flushReq = fl; sbAck = ack;
    sbExists = ex; sbId = sid; procDone = done; dispReady = rdy;
    @(posedge clk);
    #1;
    cmdValid = 1'b0; cmdId = 8'h00; flushReq = 1'b0; sbAck = 1'b0;
    sbExists = 1'b0; sbId = 2'd0; procDone = 4'h0; dispReady = 1'b1;
  endtask

  task automatic tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
  endtask

  task automatic missTxn(input logic [7:0] id, input logic [1:0] expProc,
                         input logic [3:0] expBusy, input int hold);
    applyStimulus(1'b1, id, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("miss_read", {sbRead, sbCmdId}, {1'b1, id});
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    tick();
    checkOutput("miss_write", {sbWrite, sbCmdId, sbProcId}, {1'b1, id, expProc});
    tick();
    checkOutput("miss_busy", busyMap, expBusy);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("miss_disp", {dispValid, dispCmdId, dispProcId}, {1'b1, id, expProc});
    for (int i = 0; i < hold; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
      checkOutput("disp_hold", {dispValid, dispCmdId, dispProcId}, {1'b1, id, expProc});
    end
    tick();
    checkOutput("miss_idle", {dispValid, cmdReady}, 2'b01);
  endtask

  function automatic int lowestFree(input logic [3:0] b);
    for (int k = 0; k < 4; k++) if (!b[k]) return k;
    return -1;
  endfunction

  // Model state: what is outstanding, what the processors hold, what must show next cycle.
  bit         mIdle, mRdWait, mWrWait, mFlWait, mAllocPend, mDispPend, mErr;
  bit         mExpRead, mExpWrite, mExpFlush;
  int         mWait;
  logic [3:0] mBusy;
  logic [7:0] mCmd;
  logic [1:0] mProc;

  always @(negedge clk) begin
    logic [3:0] nBusy;
    bit         nRead, nWrite, nFlush;
    int         lf;
    if (!rstn) begin
      checkOutput("m_reset", {cmdReady, sbRead, sbWrite, sbFlush, dispValid, err, busyMap,
                              sbCmdId, sbProcId, dispCmdId, dispProcId}, 32'h0);
      mIdle = 1'b1; mRdWait = 1'b0; mWrWait = 1'b0; mFlWait = 1'b0;
      mAllocPend = 1'b0; mDispPend = 1'b0; mErr = 1'b0;
      mExpRead = 1'b0; mExpWrite = 1'b0; mExpFlush = 1'b0;
      mWait = 0; mBusy = 4'h0; mCmd = 8'h00; mProc = 2'd0;
    end else begin
      checkOutput("m_ready", cmdReady, mIdle && !flushReq);
      checkOutput("m_read", sbRead, mExpRead);
      checkOutput("m_write", sbWrite, mExpWrite);
      checkOutput("m_flush", sbFlush, mExpFlush);
      checkOutput("m_disp", dispValid, mDispPend);
      checkOutput("m_busy", busyMap, mBusy);
      checkOutput("m_err", err, mErr);
      if (mExpRead)  checkOutput("m_rd_cmd", sbCmdId, mCmd);
      if (mExpWrite) checkOutput("m_wr_fields", {sbCmdId, sbProcId}, {mCmd, mProc});
      if (mDispPend) checkOutput("m_disp_fields", {dispCmdId, dispProcId}, {mCmd, mProc});

      nBusy = mBusy & ~procDone;
      if (mExpWrite) nBusy[mProc] = 1'b1;
      nRead = 1'b0; nWrite = 1'b0; nFlush = 1'b0;
      if (mIdle) begin
        if (flushReq) begin
          mIdle = 1'b0; nFlush = 1'b1;
        end else if (cmdValid) begin
          mIdle = 1'b0; nRead = 1'b1; mCmd = cmdId;
        end
      end
      if (mDispPend && dispReady) begin
        mDispPend = 1'b0; mIdle = 1'b1;
      end
      if (mAllocPend) begin
        lf = lowestFree(mBusy);
        if (lf >= 0) begin
          mAllocPend = 1'b0; nWrite = 1'b1; mProc = 2'(lf);
        end
      end
      if (mExpRead) begin
        mRdWait = 1'b1; mWait = 0;
      end else if (mExpWrite) begin
        mWrWait = 1'b1; mWait = 0;
      end else if (mExpFlush) begin
        mFlWait = 1'b1; mWait = 0;
      end else if (mRdWait || mWrWait || mFlWait) begin
        if (sbAck) begin
          if (mRdWait) begin
            if (sbExists) begin
              mProc = sbId; mDispPend = 1'b1;
            end else begin
              mAllocPend = 1'b1;
            end
          end else if (mWrWait) begin
            mDispPend = 1'b1;
          end else begin
            nBusy = 4'h0; mErr = 1'b0; mIdle = 1'b1;
          end
          mRdWait = 1'b0; mWrWait = 1'b0; mFlWait = 1'b0;
        end else begin
          mWait++;
          if (mWait == TIMEOUT) begin
            mErr = 1'b1; mIdle = 1'b1;
            mRdWait = 1'b0; mWrWait = 1'b0; mFlWait = 1'b0;
          end
        end
      end
      mBusy = nBusy; mExpRead = nRead; mExpWrite = nWrite; mExpFlush = nFlush;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmdValid = 1'b0; cmdId = 8'h00; flushReq = 1'b0; sbAck = 1'b0;
    sbExists = 1'b0; sbId = 2'd0; procDone = 4'h0; dispReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", {cmdReady, busyMap, err, sbRead, sbWrite, sbFlush, dispValid}, 32'h0);
    rstn = 1'b1;
    #1;
    checkOutput("rel_ready", cmdReady, 1'b1);

    // Misses allocate processors 0 then 1; the first dispatch is held off two cycles.
    missTxn(8'd5, 2'd0, 4'b0001, 2);
    missTxn(8'd6, 2'd1, 4'b0011, 0);

    // Hit: accept at N, read at N+1, ack at N+2, dispatch at N+3, no write.
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("hit_read", {sbRead, sbCmdId}, {1'b1, 8'd2});
    tick();
    checkOutput("hit_wait", {sbRead, dispValid}, 2'b00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 1'b1);
    checkOutput("hit_disp", {dispValid, dispCmdId, dispProcId, sbWrite, busyMap},
                {1'b1, 8'd2, 2'd3, 1'b0, 4'b0011});
    tick();
    checkOutput("hit_idle", {dispValid, cmdReady}, 2'b01);

    missTxn(8'd7, 2'd2, 4'b0111, 0);
    missTxn(8'd8, 2'd3, 4'b1111, 0);

    // All processors busy: allocation stalls until processor 2 finishes.
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_nowrite", {sbWrite, busyMap}, {1'b0, 4'b1111});
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1);
    checkOutput("stall_freed", {sbWrite, busyMap}, {1'b0, 4'b1011});
    tick();
    checkOutput("stall_write", {sbWrite, sbCmdId, sbProcId}, {1'b1, 8'd9, 2'd2});
    tick();
    checkOutput("stall_busy", busyMap, 4'b1111);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("stall_disp", {dispValid, dispCmdId, dispProcId}, {1'b1, 8'd9, 2'd2});
    tick();

    // Lookup never acknowledged: error after exactly TIMEOUT waiting cycles.
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("to_read", sbRead, 1'b1);
    repeat (TIMEOUT) tick();
    checkOutput("to_before", {err, cmdReady}, 2'b00);
    tick();
    checkOutput("to_after", {err, cmdReady, dispValid, busyMap}, {1'b1, 1'b1, 1'b0, 4'b1111});

    // Flush beats a same-cycle command, then clears the map and the error.
    applyStimulus(1'b1, 8'd11, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("fl_pulse", {sbFlush, sbRead, err}, 3'b101);
    tick();
    checkOutput("fl_wait", sbFlush, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("fl_done", {busyMap, err, cmdReady}, {4'b0000, 1'b0, 1'b1});
    missTxn(8'd11, 2'd0, 4'b0001, 0);

    // Reset in the middle of a write wait with processor 1 the only busy one.
    applyStimulus(1'b1, 8'd12, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    tick();
    checkOutput("rw_write", {sbWrite, sbProcId}, {1'b1, 2'd1});
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1);
    checkOutput("rw_busy", busyMap, 4'b0010);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rw_reset", {cmdReady, busyMap, err, sbRead, sbWrite, sbFlush, dispValid,
                             sbCmdId, sbProcId}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rw_quiet", {dispValid, sbWrite, sbRead, busyMap, err, cmdReady}, 9'b000_0000_01);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
